boot_rom_arbiter: RTL



---
 rtl/boot_rom_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/boot_rom_arbiter.sv
// Round-robin arbiter that shares a single-port boot ROM between the instruction
// fetch port and the data port, with address decode and a one-cycle response stage.
module boot_rom_arbiter #(
    parameter int unsigned ROM_ADDR_WIDTH = 12,
    parameter logic [31:0] ROM_START_ADDR = 32'h8000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      instr_req_i,
    input  logic [31:0]               instr_addr_i,
    output logic                      instr_gnt_o,
    output logic                      instr_rvalid_o,
    output logic [31:0]               instr_rdata_o,
    output logic                      instr_err_o,
    input  logic                      data_req_i,
    input  logic [31:0]               data_addr_i,
    input  logic                      data_we_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    output logic [31:0]               data_rdata_o,
    output logic                      data_err_o,
    output logic                      rom_en_o,
    output logic [ROM_ADDR_WIDTH-3:0] rom_addr_o,
    input  logic [31:0]               rom_rdata_i
);

    localparam int unsigned WORD_W  = ROM_ADDR_WIDTH - 2;
    // 33-bit end bound so a region touching the top of the address map cannot wrap.
    localparam logic [32:0] ROM_END = {1'b0, ROM_START_ADDR} + (33'd1 << ROM_ADDR_WIDTH);

    logic              prio_q;      // 0: instr wins a tie, 1: data wins a tie
    logic              rsp_valid_q;
    logic              rsp_port_q;  // 0: instr, 1: data
    logic              rsp_err_q;
    logic [WORD_W-1:0] rom_addr_q;

    logic              contended;
    logic              instr_win;
    logic              data_win;
    logic              any_gnt;
    logic [31:0]       sel_addr;
    logic              sel_hit;
    logic              sel_ok;
    logic [WORD_W-1:0] sel_word;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        contended = instr_req_i & data_req_i;
        data_win  = data_req_i & (~instr_req_i | prio_q);
        instr_win = instr_req_i & ~data_win;
        any_gnt   = instr_win | data_win;
        sel_addr  = data_win ? data_addr_i : instr_addr_i;
        sel_hit   = ({1'b0, sel_addr} >= {1'b0, ROM_START_ADDR}) && ({1'b0, sel_addr} < ROM_END);
        sel_ok    = sel_hit & ~(data_win & data_we_i);
        sel_word  = sel_addr[ROM_ADDR_WIDTH-1:2];
    end

    assign instr_gnt_o = instr_win;
    assign data_gnt_o  = data_win;
    assign rom_en_o    = any_gnt & sel_ok;
    // The macro address is presented combinationally in the grant cycle and held otherwise.
    assign rom_addr_o  = rom_en_o ? sel_word : rom_addr_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rom_addr_q  <= '0;
        end else begin
            if (contended) begin
                prio_q <= ~prio_q;
            end
            if (rom_en_o) begin
                rom_addr_q <= sel_word;
            end
            rsp_valid_q <= any_gnt;
            rsp_port_q  <= data_win;
            rsp_err_q   <= ~sel_ok;
        end
    end

    assign instr_rvalid_o = rsp_valid_q & ~rsp_port_q;
    assign data_rvalid_o  = rsp_valid_q & rsp_port_q;
    assign instr_err_o    = instr_rvalid_o & rsp_err_q;
    assign data_err_o     = data_rvalid_o & rsp_err_q;
    assign instr_rdata_o  = (instr_rvalid_o & ~rsp_err_q) ? rom_rdata_i : 32'h0;
    assign data_rdata_o   = (data_rvalid_o & ~rsp_err_q) ? rom_rdata_i : 32'h0;

endmodule
